// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select codes and the PC-stage FSM state type.
package cpu_pkg;

  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JMP = 2'b10;
  localparam logic [1:0] PC_SEL_RSV = 2'b11;

  typedef enum logic [1:0] {
    BOOT   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10,
    FAULT  = 2'b11
  } pc_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC arithmetic: PC+4, branch and jump targets, selected next PC.
module pc_target_calc
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [1:0]        pc_sel,
  input  logic [15:0]       branch_offset,
  input  logic [25:0]       jump_index,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] branch_tgt,
  output logic [ADDR_W-1:0] jump_tgt,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] branch_disp;

  assign pc_plus4    = pc + ADDR_W'(4);
  assign branch_disp = {{(ADDR_W-18){branch_offset[15]}}, branch_offset, 2'b00};
  assign branch_tgt  = pc_plus4 + branch_disp;

  // With a 28-bit PC the jump field covers the whole address, so no region bits remain.
  if (ADDR_W > 28) begin : g_jump_region
    assign jump_tgt = {pc_plus4[ADDR_W-1:28], jump_index, 2'b00};
  end else begin : g_jump_full
    assign jump_tgt = {jump_index, 2'b00};
  end

  always_comb begin
    next_pc = pc_plus4;
    case (pc_sel)
      PC_SEL_BR:  next_pc = branch_tgt;
      PC_SEL_JMP: next_pc = jump_tgt;
      default:    next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter stage: PC register, boot/run/halt/fault control and retired-instruction counter.
module pc_next_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       IMEM_WORDS = 256,
  parameter int unsigned       CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        pc_sel,
  input  logic [15:0]       branch_offset,
  input  logic [25:0]       jump_index,
  input  logic              stall,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              pc_valid,
  output logic              halted,
  output logic              pc_fault,
  output logic [CNT_W-1:0]  retired
);

  // Limit computed in 64 bits so a memory spanning the full address space never faults.
  localparam longint unsigned PC_LIMIT = longint'(IMEM_WORDS) * 64'd4;

  pc_state_e         state;
  logic [ADDR_W-1:0] next_pc;
  logic              out_of_range;

  pc_target_calc #(
    .ADDR_W(ADDR_W)
  ) u_target_calc (
    .pc           (pc),
    .pc_sel       (pc_sel),
    .branch_offset(branch_offset),
    .jump_index   (jump_index),
    .pc_plus4     (pc_plus4),
    .branch_tgt   (),
    .jump_tgt     (),
    .next_pc      (next_pc)
  );

  assign out_of_range = 64'(next_pc) >= PC_LIMIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      retired  <= '0;
      pc_valid <= 1'b0;
      halted   <= 1'b0;
      pc_fault <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state    <= RUN;
          pc_valid <= 1'b1;
        end
        RUN: begin
          if (halt) begin
            state    <= HALTED;
            pc_valid <= 1'b0;
            halted   <= 1'b1;
          end else if (!stall) begin
            if (out_of_range) begin
              state    <= FAULT;
              pc_valid <= 1'b0;
              pc_fault <= 1'b1;
            end else begin
              pc      <= next_pc;
              retired <= retired + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed vector table, corner sequences, randomized model run.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst_main, rst_small, rst_wrap;
  logic [1:0]  pc_sel;
  logic [15:0] branch_offset;
  logic [25:0] jump_index;
  logic        stall, halt;

  logic [31:0] pc_m, pp4_m, ret_m, pc_s, pp4_s, ret_s, pc_w, pp4_w, ret_w;
  logic        val_m, hlt_m, flt_m, val_s, hlt_s, flt_s, val_w, hlt_w, flt_w;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  pc_next_unit #(.ADDR_W(32), .RESET_PC(32'h0), .IMEM_WORDS(256), .CNT_W(32)) u_main (
    .clk(clk), .rst_n(rst_main), .pc_sel(pc_sel), .branch_offset(branch_offset),
    .jump_index(jump_index), .stall(stall), .halt(halt), .pc(pc_m), .pc_plus4(pp4_m),
    .pc_valid(val_m), .halted(hlt_m), .pc_fault(flt_m), .retired(ret_m));

  pc_next_unit #(.ADDR_W(32), .RESET_PC(32'h0), .IMEM_WORDS(16), .CNT_W(32)) u_small (
    .clk(clk), .rst_n(rst_small), .pc_sel(pc_sel), .branch_offset(branch_offset),
    .jump_index(jump_index), .stall(stall), .halt(halt), .pc(pc_s), .pc_plus4(pp4_s),
    .pc_valid(val_s), .halted(hlt_s), .pc_fault(flt_s), .retired(ret_s));

  pc_next_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .IMEM_WORDS(32'h4000_0000), .CNT_W(32)) u_wrap (
    .clk(clk), .rst_n(rst_wrap), .pc_sel(pc_sel), .branch_offset(branch_offset),
    .jump_index(jump_index), .stall(stall), .halt(halt), .pc(pc_w), .pc_plus4(pp4_w),
    .pc_valid(val_w), .halted(hlt_w), .pc_fault(flt_w), .retired(ret_w));

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] off;
    logic [25:0] jidx;
    logic        st;
    logic        ht;
    logic [31:0] pc;
    logic [31:0] ret;
    logic        valid;
    logic        hlt;
    logic        flt;
  } vec_t;

  vec_t tbl[20];

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] s, input logic [15:0] o, input logic [25:0] j,
                        input logic st, input logic ht);
    pc_sel = s; branch_offset = o; jump_index = j; stall = st; halt = ht;
  endtask

  task automatic check_main(input string tag, input logic [31:0] p, input logic [31:0] r,
                            input logic v, input logic h, input logic f);
    check({tag, ".pc"}, pc_m, p);
    check({tag, ".pc_plus4"}, pp4_m, p + 32'd4);
    check({tag, ".retired"}, ret_m, r);
    check({tag, ".pc_valid"}, val_m, v);
    check({tag, ".halted"}, hlt_m, h);
    check({tag, ".pc_fault"}, flt_m, f);
  endtask

  // Reference model state: plain arithmetic on the architectural rules.
  longint unsigned m_pc, m_ret;
  bit m_booted, m_halt, m_fault;

  task automatic model_reset();
    m_pc = 0; m_ret = 0; m_booted = 0; m_halt = 0; m_fault = 0;
  endtask

  task automatic model_edge(input logic [1:0] s, input logic [15:0] o, input logic [25:0] j,
                            input logic st, input logic ht);
    longint unsigned seq, tgt;
    longint signed   disp;
    if (!m_booted) m_booted = 1;
    else if (m_halt || m_fault) begin end
    else if (ht) m_halt = 1;
    else if (!st) begin
      seq  = (m_pc + 4) % 64'h1_0000_0000;
      disp = longint'($signed(o)) * 4;
      if (s == 2'b01)      tgt = longint'(seq + disp) & 64'hFFFF_FFFF;
      else if (s == 2'b10) tgt = (seq & 64'hF000_0000) | (longint'(j) * 4);
      else                 tgt = seq;
      if (tgt >= 256 * 4) m_fault = 1;
      else begin
        m_pc  = tgt;
        m_ret = (m_ret + 1) % 64'h1_0000_0000;
      end
    end
  endtask

  task automatic reset_main();
    #2 rst_main = 1'b0;
    model_reset();
    #1 check("rst_async.pc", pc_m, 0);
    check("rst_async.pc_valid", val_m, 0);
    @(negedge clk) rst_main = 1'b1;
    #1;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_main = 1'b0; rst_small = 1'b0; rst_wrap = 1'b0;
    set_in(2'b00, 16'h0, 26'h0, 1'b0, 1'b0);

    //                 sel    off       jidx      st  ht  pc        ret  v  h  f
    tbl[0]  = '{2'b00, 16'h0000, 26'h00, 0, 0, 32'h00, 0,  1, 0, 0};
    tbl[1]  = '{2'b00, 16'h0000, 26'h00, 0, 0, 32'h04, 1,  1, 0, 0};
    tbl[2]  = '{2'b00, 16'h0000, 26'h00, 0, 0, 32'h08, 2,  1, 0, 0};
    tbl[3]  = '{2'b00, 16'h0000, 26'h00, 0, 0, 32'h0C, 3,  1, 0, 0};
    tbl[4]  = '{2'b00, 16'h0000, 26'h00, 0, 0, 32'h10, 4,  1, 0, 0};
    tbl[5]  = '{2'b01, 16'h0004, 26'h00, 0, 0, 32'h24, 5,  1, 0, 0};
    tbl[6]  = '{2'b10, 16'h0000, 26'h04, 0, 0, 32'h10, 6,  1, 0, 0};
    tbl[7]  = '{2'b01, 16'hFFFB, 26'h00, 0, 0, 32'h00, 7,  1, 0, 0};
    tbl[8]  = '{2'b00, 16'h0000, 26'h00, 0, 0, 32'h04, 8,  1, 0, 0};
    tbl[9]  = '{2'b00, 16'h0000, 26'h00, 0, 0, 32'h08, 9,  1, 0, 0};
    tbl[10] = '{2'b10, 16'h0000, 26'h20, 0, 0, 32'h80, 10, 1, 0, 0};
    tbl[11] = '{2'b10, 16'h0000, 26'h05, 0, 0, 32'h14, 11, 1, 0, 0};
    tbl[12] = '{2'b00, 16'h0000, 26'h00, 1, 0, 32'h14, 11, 1, 0, 0};
    tbl[13] = '{2'b01, 16'h0004, 26'h00, 1, 0, 32'h14, 11, 1, 0, 0};
    tbl[14] = '{2'b10, 16'h0000, 26'h08, 0, 0, 32'h20, 12, 1, 0, 0};
    tbl[15] = '{2'b11, 16'h0000, 26'h00, 0, 0, 32'h24, 13, 1, 0, 0};
    tbl[16] = '{2'b10, 16'h0000, 26'h05, 0, 0, 32'h14, 14, 1, 0, 0};
    tbl[17] = '{2'b00, 16'h0000, 26'h00, 1, 1, 32'h14, 14, 0, 1, 0};
    tbl[18] = '{2'b01, 16'h0004, 26'h00, 0, 0, 32'h14, 14, 0, 1, 0};
    tbl[19] = '{2'b10, 16'h0000, 26'h20, 1, 0, 32'h14, 14, 0, 1, 0};

    repeat (2) @(posedge clk);
    #1 check_main("reset", 32'h0, 0, 0, 0, 0);
    @(negedge clk) rst_main = 1'b1;
    #1 check_main("boot", 32'h0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      set_in(tbl[i].sel, tbl[i].off, tbl[i].jidx, tbl[i].st, tbl[i].ht);
      step();
      check_main($sformatf("tbl[%0d]", i), tbl[i].pc, tbl[i].ret, tbl[i].valid, tbl[i].hlt, tbl[i].flt);
    end

    // Async reset out of HALTED, between clock edges.
    #2 rst_main = 1'b0;
    #1 check_main("halt_rst", 32'h0, 0, 0, 0, 0);

    // Small memory: jump to 0x80 is out of range and faults at pc 0x08.
    set_in(2'b00, 16'h0, 26'h0, 1'b0, 1'b0);
    @(negedge clk) rst_small = 1'b1;
    step(); step(); step();
    check("small.pc_pre", pc_s, 32'h08);
    set_in(2'b10, 16'h0, 26'h20, 1'b0, 1'b0);
    step();
    check("small.fault", flt_s, 1);
    check("small.valid", val_s, 0);
    check("small.pc", pc_s, 32'h08);
    check("small.retired", ret_s, 2);
    set_in(2'b00, 16'h0, 26'h0, 1'b0, 1'b0);
    step();
    check("small.fault_hold_pc", pc_s, 32'h08);
    #2 rst_small = 1'b0;
    #1 check("small.rst_pc", pc_s, 0);
    check("small.rst_fault", flt_s, 0);
    check("small.rst_valid", val_s, 0);
    @(negedge clk) rst_small = 1'b1;
    #1 check("small.boot_valid", val_s, 0);
    step(); step(); step();
    // Halt beats an out-of-range jump.
    set_in(2'b10, 16'h0, 26'h20, 1'b0, 1'b1);
    step();
    check("small.halt_vs_oor.halted", hlt_s, 1);
    check("small.halt_vs_oor.fault", flt_s, 0);
    check("small.halt_vs_oor.pc", pc_s, 32'h08);
    // Last legal word 0x3C is reachable, 0x40 is not.
    #2 rst_small = 1'b0;
    set_in(2'b10, 16'h0, 26'h0F, 1'b0, 1'b0);
    @(negedge clk) rst_small = 1'b1;
    step(); step();
    check("small.edge_ok.pc", pc_s, 32'h3C);
    check("small.edge_ok.fault", flt_s, 0);
    set_in(2'b00, 16'h0, 26'h0, 1'b0, 1'b0);
    step();
    check("small.edge_oor.fault", flt_s, 1);
    check("small.edge_oor.pc", pc_s, 32'h3C);

    // Full address space: PC wraps from the top word to zero without fault.
    @(negedge clk) rst_wrap = 1'b1;
    #1 check("wrap.boot_pc", pc_w, 32'hFFFF_FFFC);
    check("wrap.pc_plus4", pp4_w, 32'h0);
    step(); step();
    check("wrap.pc", pc_w, 32'h0);
    check("wrap.retired", ret_w, 1);
    check("wrap.fault", flt_w, 0);
    check("wrap.valid", val_w, 1);

    // Randomized run against the reference model.
    reset_main();
    for (int n = 0; n < 600; n++) begin
      if ((m_halt || m_fault) && $urandom_range(0, 3) == 0) reset_main();
      set_in(2'($urandom_range(0, 3)), 16'($signed($urandom_range(0, 40)) - 20),
             26'($urandom_range(0, 300)), $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0);
      model_edge(pc_sel, branch_offset, jump_index, stall, halt);
      step();
      check_main($sformatf("rand[%0d]", n), 32'(m_pc), 32'(m_ret),
                 m_booted && !m_halt && !m_fault, m_halt, m_fault);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
